// File: rtl/det_4x4_loader.sv
// Streaming loader for the 4x4 determinant unit: collects 16 bytes, holds them on mat_out,
// waits for the combinational result to settle and hands it out over valid/ready.
module det_4x4_loader #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [127:0] mat_out,
    input  logic [7:0]   det_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         busy
);

    typedef enum logic [1:0] {StLoad, StSettle, StOutput} state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e     state;
    logic [3:0] elem_cnt;
    logic [3:0] settle_cnt;

    assign in_ready = (state == StLoad);
    assign busy     = (state != StLoad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StLoad;
            elem_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
            mat_out    <= '0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
        end else if (clear) begin
            // Abort wins over any element accept or output handshake on this edge
            state      <= StLoad;
            elem_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
            mat_out    <= '0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                StLoad: begin
                    if (in_valid) begin
                        mat_out[{elem_cnt, 3'b000} +: 8] <= in_data;
                        if (elem_cnt == 4'd15) begin
                            elem_cnt   <= 4'd0;
                            settle_cnt <= 4'd0;
                            state      <= StSettle;
                        end else begin
                            elem_cnt <= elem_cnt + 4'd1;
                        end
                    end
                end
                StSettle: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SettleLast) begin
                        out_data  <= det_in;
                        out_valid <= 1'b1;
                        state     <= StOutput;
                    end
                end
                StOutput: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StLoad;
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_det_4x4_loader.sv
// Scoreboard bench for det_4x4_loader: a behavioural determinant model feeds det_in and
// predicts each result; two instances cover SETTLE_CYCLES=2 and SETTLE_CYCLES=1.
module tb_det_4x4_loader;

    logic         clk = 1'b0;
    logic         rst, clear, in_valid, out_ready, sel;
    logic [7:0]   in_data;

    logic         in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
    logic [127:0] mat0, mat1;
    logic [7:0]   det0, det1, out_data0, out_data1;

    logic         cur_in_ready, cur_out_valid, cur_busy;
    logic [127:0] cur_mat;
    logic [7:0]   cur_out_data;

    int n_cmp = 0;
    int n_err = 0;
    int xfer_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic int det3(input int a, b, c, d, e, f, g, h, i);
        return a * (e * i - f * h) - b * (d * i - f * g) + c * (d * h - e * g);
    endfunction

    function automatic logic [7:0] det_model(input logic [127:0] m);
        int e[16];
        int d;
        int cs[3];
        int k;
        for (int i = 0; i < 16; i++) e[i] = int'(m[i*8 +: 8]);
        d = 0;
        for (int j = 0; j < 4; j++) begin
            k = 0;
            for (int c = 0; c < 4; c++) if (c != j) begin cs[k] = c; k++; end
            d += ((j % 2 == 0) ? 1 : -1) * e[j] *
                 det3(e[4+cs[0]], e[4+cs[1]], e[4+cs[2]],
                      e[8+cs[0]], e[8+cs[1]], e[8+cs[2]],
                      e[12+cs[0]], e[12+cs[1]], e[12+cs[2]]);
        end
        return 8'(d);
    endfunction

    function automatic logic [127:0] pack(input logic [7:0] el[16]);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = el[i];
        return r;
    endfunction

    assign det0 = det_model(mat0);
    assign det1 = det_model(mat1);

    det_4x4_loader #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid & ~sel), .in_ready(in_ready0),
        .in_data(in_data), .mat_out(mat0), .det_in(det0), .out_valid(out_valid0),
        .out_ready(out_ready & ~sel), .out_data(out_data0), .busy(busy0)
    );

    det_4x4_loader #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid & sel), .in_ready(in_ready1),
        .in_data(in_data), .mat_out(mat1), .det_in(det1), .out_valid(out_valid1),
        .out_ready(out_ready & sel), .out_data(out_data1), .busy(busy1)
    );

    assign cur_in_ready  = sel ? in_ready1  : in_ready0;
    assign cur_out_valid = sel ? out_valid1 : out_valid0;
    assign cur_busy      = sel ? busy1      : busy0;
    assign cur_mat       = sel ? mat1       : mat0;
    assign cur_out_data  = sel ? out_data1  : out_data0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer: inputs are stable at the negedge preceding the transfer edge
    always @(negedge clk) begin
        if (!rst && !clear && cur_out_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check_eq("sb_unexpected", 128'(exp_q.size()), 128'd1);
            else check_eq("sb_det", {120'd0, cur_out_data}, {120'd0, exp_q.pop_front()});
        end
    end

    task automatic send(input logic [7:0] el[16], input int n, input int max_gap);
        logic acc;
        int   guard;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
            in_valid = 1'b1;
            in_data  = el[i];
            guard    = 0;
            do begin
                acc = cur_in_ready;
                tick();
                guard++;
            end while (!acc && guard < 100);
            if (!acc) check_eq("accept_timeout", {127'd0, acc}, 128'd1);
            in_valid = 1'b0;
        end
        if (n == 16) exp_q.push_back(det_model(pack(el)));
    endtask

    task automatic wait_out();
        int guard = 0;
        while (!cur_out_valid && guard < 50) begin
            tick();
            guard++;
        end
        check_eq("out_valid_rise", {127'd0, cur_out_valid}, 128'd1);
    endtask

    // After the final accept: count in_ready-low cycles and out_valid pulses
    task automatic watch_handshake(output int low_cnt, output int ov_cnt, output int first_ov);
        low_cnt  = 0;
        ov_cnt   = 0;
        first_ov = 0;
        for (int k = 1; k < 40; k++) begin
            if (cur_in_ready) break;
            low_cnt++;
            if (cur_out_valid) begin
                ov_cnt++;
                if (first_ov == 0) begin
                    first_ov = k;
                    check_eq("out_data_now", {120'd0, cur_out_data}, {120'd0, exp_q[0]});
                end
            end
            tick();
        end
    endtask

    logic [7:0] m1[16]    = '{2, 3, 1, 4, 1, 1, 2, 3, 3, 4, 5, 6, 7, 8, 9, 10};
    logic [7:0] mneg[16]  = '{1, 1, 2, 3, 2, 3, 1, 4, 3, 4, 5, 6, 7, 8, 9, 10};
    logic [7:0] ident[16] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [7:0] m2[16]    = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6, 7, 8};
    logic [7:0] m3[16]    = '{3, 200, 17, 5, 9, 4, 77, 1, 250, 6, 2, 8, 11, 13, 99, 7};

    initial begin
        logic [127:0] partial;
        int low_cnt, ov_cnt, first_ov, xfer_before;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0; sel = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_eq("rst_mat", mat0, 128'd0);
        check_eq("rst_out_valid", {127'd0, out_valid0}, 128'd0);
        check_eq("rst_out_data", {120'd0, out_data0}, 128'd0);
        check_eq("rst_in_ready", {127'd0, in_ready0}, 128'd1);
        check_eq("rst_busy", {127'd0, busy0}, 128'd0);

        // Back-to-back load, consumer always ready
        out_ready = 1'b1;
        send(m1, 16, 0);
        check_eq("m1_mat", mat0, pack(m1));
        check_eq("m1_byte_a", {120'd0, mat0[7:0]}, 128'h02);
        check_eq("m1_byte_p", {120'd0, mat0[127:120]}, 128'h0A);
        check_eq("m1_det_const", {120'd0, exp_q[0]}, 128'd20);
        watch_handshake(low_cnt, ov_cnt, first_ov);
        check_eq("m1_ready_low", 128'(low_cnt), 128'd3);
        check_eq("m1_ov_pulses", 128'(ov_cnt), 128'd1);
        check_eq("m1_ov_timing", 128'(first_ov), 128'd3);

        // Identity with gaps, stalled consumer, junk input during SETTLE/OUTPUT
        out_ready = 1'b0;
        send(ident, 16, 3);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        wait_out();
        for (int i = 0; i < 5; i++) begin
            check_eq("id_hold_valid", {127'd0, out_valid0}, 128'd1);
            check_eq("id_hold_data", {120'd0, out_data0}, 128'd1);
            check_eq("id_busy", {127'd0, busy0}, 128'd1);
            tick();
        end
        check_eq("id_mat_no_ff", mat0, pack(ident));
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("id_xfer_done", {127'd0, out_valid0}, 128'd0);
        check_eq("id_ready_back", {127'd0, in_ready0}, 128'd1);
        check_eq("id_mat_kept", mat0, pack(ident));

        // Partial load, idle, then clear colliding with an element
        send(m2, 7, 2);
        repeat (4) tick();
        partial = pack(ident);
        for (int i = 0; i < 7; i++) partial[i*8 +: 8] = m2[i];
        check_eq("part_mat", mat0, partial);
        check_eq("part_ready", {127'd0, in_ready0}, 128'd1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_mat", mat0, 128'd0);
        check_eq("clr_ready", {127'd0, in_ready0}, 128'd1);
        out_ready = 1'b1;
        send(m3, 16, 1);
        check_eq("m3_mat", mat0, pack(m3));
        wait_out();
        tick();
        check_eq("m3_done", {127'd0, out_valid0}, 128'd0);

        // Reset colliding with an output handshake
        out_ready = 1'b0;
        send(m1, 16, 0);
        wait_out();
        xfer_before = xfer_cnt;
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_back());
        check_eq("rst_o_valid", {127'd0, out_valid0}, 128'd0);
        check_eq("rst_o_data", {120'd0, out_data0}, 128'd0);
        check_eq("rst_o_mat", mat0, 128'd0);
        check_eq("rst_o_ready", {127'd0, in_ready0}, 128'd1);
        check_eq("rst_o_noxfer", 128'(xfer_cnt), 128'(xfer_before));

        // SETTLE_CYCLES=1 instance, negative determinant
        sel       = 1'b1;
        out_ready = 1'b1;
        send(mneg, 16, 0);
        check_eq("s1_det_const", {120'd0, exp_q[0]}, 128'hEC);
        watch_handshake(low_cnt, ov_cnt, first_ov);
        check_eq("s1_ready_low", 128'(low_cnt), 128'd2);
        check_eq("s1_ov_timing", 128'(first_ov), 128'd2);
        check_eq("s1_busy_idle", {127'd0, cur_busy}, 128'd0);
        out_ready = 1'b0;
        tick();

        check_eq("sb_drained", 128'(exp_q.size()), 128'd0);
        check_eq("xfer_total", 128'(xfer_cnt), 128'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
